// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : vga_pkg
//  Purpose  : Shared geometry constants, pixel type and fetch FSM states for
//             the framebuffer scanout arbiter and its line buffer.
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int SCALE    = 4;
    localparam int ADDR_W   = 15;
    localparam int COL_W    = 8;

    typedef logic [8:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : vga_line_buffer
//  Purpose  : Ping-pong line buffer, two banks of FB_W pixels. One synchronous
//             write port (fetch side) and one combinational read port
//             (display side). Out-of-range indices are ignored / read as 0.
//  Revision : 1.0  initial release
// ============================================================================
module vga_line_buffer
    import vga_pkg::*;
(
    input  logic             clk_pix,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [COL_W-1:0] wr_idx,
    input  pixel_t           wr_data,
    input  logic             rd_bank,
    input  logic [COL_W-1:0] rd_idx,
    output pixel_t           rd_data
);

    localparam logic [COL_W-1:0] DEPTH = COL_W'(FB_W);

    pixel_t mem [2][FB_W];

    // Store one fetched pixel into the selected bank; pure datapath, no reset.
    always_ff @(posedge clk_pix) begin
        if (wr_en && (wr_idx < DEPTH)) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    // Display read; indices past the row (horizontal blanking) return black.
    always_comb begin
        rd_data = '0;
        if (rd_idx < DEPTH) begin
            rd_data = mem[rd_bank][rd_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_scanout_arb.sv
`default_nettype none
// ============================================================================
//  Module   : vga_fb_scanout_arb
//  Purpose  : Shares a single-port 160x120 RGB333 framebuffer between row
//             prefetch for the display and an external pixel writer. Rows are
//             prefetched into a ping-pong line buffer and shown with 4x pixel
//             and line replication at 640x480.
//  Option   : VGA_FB_WR_FAIR_EN - fetch reads only on alternate cycles so the
//             writer keeps every other RAM cycle during a fetch.
//  Revision : 1.0  initial release
// ============================================================================
module vga_fb_scanout_arb
    import vga_pkg::*;
(
    input  logic              clk_pix,
    input  logic              resetn,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              de,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_we,
    output logic [8:0]        fb_wdata,
    input  logic [8:0]        fb_rdata,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [8:0]        wr_data,
    output logic              wr_ready,
    output logic [2:0]        rgb_r,
    output logic [2:0]        rgb_g,
    output logic [2:0]        rgb_b,
    output logic              underrun
);

    localparam logic [9:0]        V_ACTIVE_C = 10'(V_ACTIVE);
    localparam logic [9:0]        LAST_ROW_V = 10'(V_ACTIVE - SCALE);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(FB_W - 1);
    localparam logic [COL_W-1:0]  COL_ONE    = COL_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(FB_W);

    fetch_state_t      state;
    logic              run;
    logic              disp_bank;
    logic              frame_valid;
    logic              fetch_bank;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] row_base;
    logic              cap_valid;
    logic              cap_bank;
    logic [COL_W-1:0]  cap_col;
`ifdef VGA_FB_WR_FAIR_EN
    logic              phase;
`endif

    logic              line_start;
    logic              swap_ev;
    logic              vblank_ev;
    logic              trig_ev;
    logic              start_fetch;
    logic              fetch_slot;
    logic              rd_issue;
    logic [ADDR_W-1:0] trig_base;
    logic              trig_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [COL_W-1:0]  rd_col;
    logic              rd_bank;
    logic              accept;
    logic              disp_sel;
    logic              show;
    pixel_t            disp_pix;

    // Row boundaries: a swap every SCALE lines of active video (SCALE = 4, so
    // the low two vcount bits mark the row start), plus one vblank trigger
    // that prefetches row 0 for the next frame.
    assign line_start  = run && (hcount == 10'd0);
    assign swap_ev     = line_start && (vcount[1:0] == 2'b00) && (vcount < V_ACTIVE_C);
    assign vblank_ev   = line_start && (vcount == V_ACTIVE_C);
    assign trig_ev     = swap_ev || vblank_ev;
    assign start_fetch = vblank_ev || (swap_ev && (vcount < LAST_ROW_V));

    // Vblank restarts at row 0 into the idle bank; a swap fetches the next row
    // into the bank that is being released by the toggle.
    assign trig_base = vblank_ev ? '0 : (row_base + ROW_STEP);
    assign trig_bank = vblank_ev ? ~disp_bank : disp_bank;

`ifdef VGA_FB_WR_FAIR_EN
    assign fetch_slot = (state == FETCH) && !phase;
`else
    assign fetch_slot = (state == FETCH);
`endif

    // Column 0 is read on the trigger cycle itself so the fetch loses no slot.
    assign rd_issue = start_fetch || (fetch_slot && !trig_ev);
    assign rd_col   = start_fetch ? '0 : col;
    assign rd_bank  = start_fetch ? trig_bank : fetch_bank;
    assign rd_addr  = start_fetch ? trig_base
                                  : (row_base + {{(ADDR_W-COL_W){1'b0}}, col});

    // Writer gets every cycle the fetch does not own; independent of wr_valid.
    assign wr_ready = run && !rd_issue;
    assign accept   = wr_valid && wr_ready;
    assign fb_we    = accept;
    assign fb_wdata = accept ? wr_data : 9'd0;
    assign fb_addr  = rd_issue ? rd_addr : (accept ? wr_addr : '0);

    // The swap edge itself already shows the new bank so rgb latency stays one
    // cycle; frame_valid is only trusted from a row-0 swap after vblank fetch.
    assign disp_sel = swap_ev ? ~disp_bank : disp_bank;
    assign show     = de && (frame_valid || (swap_ev && (vcount == 10'd0)));

    vga_line_buffer u_line_buffer (
        .clk_pix (clk_pix),
        .wr_en   (cap_valid),
        .wr_bank (cap_bank),
        .wr_idx  (cap_col),
        .wr_data (fb_rdata),
        .rd_bank (disp_sel),
        .rd_idx  (hcount[9:2]),
        .rd_data (disp_pix)
    );

    // Writer grant is held off until the first clock after reset release.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Fetch sequencer: bank/row bookkeeping, column walk and underrun abort.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            col         <= '0;
            fetch_bank  <= 1'b0;
            row_base    <= '0;
            disp_bank   <= 1'b0;
            frame_valid <= 1'b0;
            underrun    <= 1'b0;
`ifdef VGA_FB_WR_FAIR_EN
            phase       <= 1'b0;
`endif
        end else begin
            if (trig_ev && (state != IDLE)) begin
                underrun <= 1'b1;
            end
            if (swap_ev) begin
                disp_bank <= ~disp_bank;
            end
            if (swap_ev && (vcount == 10'd0)) begin
                frame_valid <= 1'b1;
            end
            if (trig_ev) begin
                if (start_fetch) begin
                    row_base   <= trig_base;
                    fetch_bank <= trig_bank;
                    col        <= COL_ONE;
                    state      <= FETCH;
`ifdef VGA_FB_WR_FAIR_EN
                    phase      <= 1'b1;
`endif
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (fetch_slot) begin
                            col <= col + COL_ONE;
                            if (col == COL_LAST) begin
                                state <= DRAIN;
                            end
`ifdef VGA_FB_WR_FAIR_EN
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
`endif
                        end
                    end
                    DRAIN:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // RAM read data arrives one cycle after the address; remember its target.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            cap_valid <= 1'b0;
            cap_bank  <= 1'b0;
            cap_col   <= '0;
        end else begin
            cap_valid <= rd_issue;
            cap_bank  <= rd_bank;
            cap_col   <= rd_col;
        end
    end

    // Registered RGB333 output, black outside active video or before a frame.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            rgb_r <= 3'd0;
            rgb_g <= 3'd0;
            rgb_b <= 3'd0;
        end else if (show) begin
            rgb_r <= disp_pix[8:6];
            rgb_g <= disp_pix[5:3];
            rgb_b <= disp_pix[2:0];
        end else begin
            rgb_r <= 3'd0;
            rgb_g <= 3'd0;
            rgb_b <= 3'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_scanout_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_scanout_arb
//  Purpose  : Self-checking bench for vga_fb_scanout_arb with a behavioural
//             single-port RAM, shortened lines and a scoreboard for rgb.
//  Option   : VGA_FB_WR_FAIR_EN selects the alternate-cycle expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_fb_scanout_arb;
    import vga_pkg::*;

    localparam int LINE_LEN = 660;
    localparam int OOR_ADDR = 19300;

    logic              clk_pix = 1'b0;
    logic              resetn;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              de;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_we;
    logic [8:0]        fb_wdata;
    logic [8:0]        fb_rdata;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [8:0]        wr_data;
    logic              wr_ready;
    logic [2:0]        rgb_r;
    logic [2:0]        rgb_g;
    logic [2:0]        rgb_b;
    logic              underrun;

    logic [8:0] ram    [0:32767];
    logic [8:0] exp_fb [0:32767];
    logic       clr_ram;
    logic [8:0] exp_q  [$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_pix = ~clk_pix;

    vga_fb_scanout_arb dut (
        .clk_pix  (clk_pix),
        .resetn   (resetn),
        .hcount   (hcount),
        .vcount   (vcount),
        .de       (de),
        .fb_addr  (fb_addr),
        .fb_we    (fb_we),
        .fb_wdata (fb_wdata),
        .fb_rdata (fb_rdata),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rgb_r    (rgb_r),
        .rgb_g    (rgb_g),
        .rgb_b    (rgb_b),
        .underrun (underrun)
    );

    // Single-port framebuffer RAM, one-cycle read latency.
    always @(posedge clk_pix) begin
        if (clr_ram) begin
            for (int i = 0; i < 32768; i++) ram[i] <= 9'd0;
        end else if (fb_we) begin
            ram[fb_addr] <= fb_wdata;
        end
        fb_rdata <= ram[fb_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic cycle_in(input int h, input int v, input logic d);
        @(posedge clk_pix);
        #1;
        hcount = 10'(h);
        vcount = 10'(v);
        de     = d;
    endtask

    // One line of timing; rgb scoreboard checked one cycle after each hcount.
    task automatic drive_line(input int v, input bit chk, input bit valid);
        logic [8:0] e;
        logic [8:0] got;
        logic       dd;
        exp_q.delete();
        for (int h = 0; h < LINE_LEN; h++) begin
            dd = (h < H_ACTIVE) && (v < V_ACTIVE);
            cycle_in(h, v, dd);
            @(negedge clk_pix);
            if (chk) begin
                if (exp_q.size() > 0) begin
                    e   = exp_q.pop_front();
                    got = {rgb_r, rgb_g, rgb_b};
                    n_checks++;
                    if (got !== e) begin
                        $display("FAIL rgb v=%0d h=%0d: got %h expected %h", v, h - 1, got, e);
                    end else begin
                        n_pass++;
                    end
                end
                exp_q.push_back((dd && valid) ? exp_fb[(v / SCALE) * FB_W + h / SCALE] : 9'd0);
            end
        end
    endtask

    task automatic test_reset();
        clr_ram  = 1'b1;
        resetn   = 1'b0;
        hcount   = 10'd0;
        vcount   = 10'd500;
        de       = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 15'd5;
        wr_data  = 9'h155;
        for (int i = 0; i < 32768; i++) exp_fb[i] = 9'd0;
        repeat (3) @(posedge clk_pix);
        #1 clr_ram = 1'b0;
        @(negedge clk_pix);
        n_checks++;
        if ({rgb_r, rgb_g, rgb_b, fb_we, wr_ready, underrun, fb_addr, fb_wdata} !== '0) begin
            $display("FAIL reset_outputs: got rgb=%h we=%b ready=%b ur=%b addr=%h wdata=%h expected all 0",
                     {rgb_r, rgb_g, rgb_b}, fb_we, wr_ready, underrun, fb_addr, fb_wdata);
        end else n_pass++;
        @(posedge clk_pix);
        #1 resetn = 1'b1;
        wr_valid = 1'b0;
        @(negedge clk_pix);
        n_checks++;
        if (wr_ready !== 1'b0) $display("FAIL ready_before_clock: got %b expected 0", wr_ready);
        else n_pass++;
        @(negedge clk_pix);
        n_checks++;
        if (wr_ready !== 1'b1) $display("FAIL ready_after_release: got %b expected 1", wr_ready);
        else n_pass++;
    endtask

    task automatic write_px(input int a, input logic [8:0] d);
        @(posedge clk_pix);
        #1;
        hcount   = 10'd700;
        vcount   = 10'd500;
        de       = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 15'(a);
        wr_data  = d;
        @(negedge clk_pix);
        n_checks++;
        if ({wr_ready, fb_we, fb_addr, fb_wdata} !== {1'b1, 1'b1, 15'(a), d}) begin
            $display("FAIL write_accept a=%0d: got ready=%b we=%b addr=%0d data=%h expected 1 1 %0d %h",
                     a, wr_ready, fb_we, fb_addr, fb_wdata, a, d);
        end else n_pass++;
        @(posedge clk_pix);
        #1 wr_valid = 1'b0;
        exp_fb[a] = d;
    endtask

    task automatic test_frame();
        drive_line(V_ACTIVE, 1'b0, 1'b0);
        for (int v = 0; v < 8; v++) drive_line(v, 1'b1, 1'b1);
        n_checks++;
        if (underrun !== 1'b0) $display("FAIL frame_underrun: got %b expected 0", underrun);
        else n_pass++;
    endtask

    task automatic test_blanking();
        logic [8:0] e;
        exp_q.delete();
        for (int h = 0; h < 9; h++) begin
            cycle_in(h, 1, 1'b0);
            @(negedge clk_pix);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({rgb_r, rgb_g, rgb_b} !== e) begin
                    $display("FAIL blank_rgb h=%0d: got %h expected %h", h - 1, {rgb_r, rgb_g, rgb_b}, e);
                end else n_pass++;
            end
            exp_q.push_back(9'd0);
        end
    endtask

    task automatic test_wr_hold();
        logic              er;
        logic [ADDR_W-1:0] ea;
        wr_valid = 1'b1;
        wr_addr  = 15'(OOR_ADDR);
        wr_data  = 9'h0AA;
        for (int k = 0; k < 400; k++) begin
            cycle_in(k, V_ACTIVE, 1'b0);
            @(negedge clk_pix);
`ifdef VGA_FB_WR_FAIR_EN
            er = (k >= 320) || (k % 2 == 1);
            ea = er ? 15'(OOR_ADDR) : 15'(k / 2);
`else
            er = (k >= 160);
            ea = er ? 15'(OOR_ADDR) : 15'(k);
`endif
            n_checks++;
            if ({wr_ready, fb_we, fb_addr} !== {er, er, ea}) begin
                $display("FAIL hold_arb k=%0d: got ready=%b we=%b addr=%0d expected %b %b %0d",
                         k, wr_ready, fb_we, fb_addr, er, er, ea);
            end else n_pass++;
        end
        for (int k = 400; k < LINE_LEN; k++) cycle_in(k, V_ACTIVE, 1'b0);
        wr_valid = 1'b0;
        for (int v = 0; v < 8; v++) drive_line(v, 1'b1, 1'b1);
    endtask

    task automatic test_underrun();
        n_checks++;
        if (underrun !== 1'b0) $display("FAIL underrun_pre: got %b expected 0", underrun);
        else n_pass++;
        drive_line(V_ACTIVE, 1'b0, 1'b0);
        drive_line(0, 1'b0, 1'b0);
        for (int h = 0; h < 10; h++) cycle_in(h, 4, 1'b1);
        cycle_in(0, 8, 1'b1);
        @(negedge clk_pix);
        n_checks++;
        if ({wr_ready, fb_addr, underrun} !== {1'b0, 15'd480, 1'b0}) begin
            $display("FAIL underrun_restart: got ready=%b addr=%0d ur=%b expected 0 480 0",
                     wr_ready, fb_addr, underrun);
        end else n_pass++;
        cycle_in(1, 8, 1'b1);
        @(negedge clk_pix);
        n_checks++;
        if (underrun !== 1'b1) $display("FAIL underrun_set: got %b expected 1", underrun);
        else n_pass++;
`ifdef VGA_FB_WR_FAIR_EN
        n_checks++;
        if (wr_ready !== 1'b1) $display("FAIL underrun_gap: got %b expected 1", wr_ready);
        else n_pass++;
        cycle_in(2, 8, 1'b1);
        @(negedge clk_pix);
`endif
        n_checks++;
        if (fb_addr !== 15'd481) $display("FAIL underrun_col1: got %0d expected 481", fb_addr);
        else n_pass++;
        drive_line(9, 1'b0, 1'b0);
        n_checks++;
        if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b expected 1", underrun);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        wr_valid = 1'b1;
        wr_addr  = 15'(OOR_ADDR);
        wr_data  = 9'h0AA;
        for (int h = 0; h < 50; h++) cycle_in(h, V_ACTIVE, 1'b0);
        @(posedge clk_pix);
        #1;
        resetn = 1'b0;
        hcount = 10'd50;
        @(negedge clk_pix);
        n_checks++;
        if ({rgb_r, rgb_g, rgb_b, fb_we, wr_ready, underrun, fb_addr, fb_wdata} !== '0) begin
            $display("FAIL midreset_outputs: got rgb=%h we=%b ready=%b ur=%b addr=%h wdata=%h expected all 0",
                     {rgb_r, rgb_g, rgb_b}, fb_we, wr_ready, underrun, fb_addr, fb_wdata);
        end else n_pass++;
        repeat (2) @(posedge clk_pix);
        #1;
        resetn   = 1'b1;
        wr_valid = 1'b0;
        for (int v = 2; v < 10; v++) drive_line(v, 1'b1, 1'b0);
        n_checks++;
        if (underrun !== 1'b0) $display("FAIL midreset_underrun: got %b expected 0", underrun);
        else n_pass++;
        drive_line(V_ACTIVE, 1'b0, 1'b0);
        for (int v = 0; v < 4; v++) drive_line(v, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        write_px(0,   9'h1FF);
        write_px(161, 9'h038);
        write_px(80,  9'h092);
        write_px(159, 9'h0C5);
        write_px(319, 9'h1A3);
        write_px(200, 9'h049);
        test_frame();
        test_blanking();
        test_wr_hold();
        test_underrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
